// File: rtl/exec_decode_unit_pkg.sv
// ----------------------------------------------------------------------------
// exec_decode_unit_pkg
// Shared constants for the EX-stage decode/execute slice: instruction opcodes,
// R-type funct codes, the 2-bit aluop classes handed from the main decoder to
// the ALU-control decoder, the 4-bit ALU operation codes, and the bit indices
// used inside the 2-bit branch control vector.
// ----------------------------------------------------------------------------
package exec_decode_unit_pkg;

    // Instruction opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type funct codes (instruction bits [5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // Classes of ALU usage chosen by the main decoder
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Bit positions inside the branch control vector
    localparam int BRANCH_BEQ = 0;
    localparam int BRANCH_BNE = 1;

endpackage

// File: rtl/exec_decode_unit_alu32.sv
// ----------------------------------------------------------------------------
// alu32
// 32-bit ALU with a zero flag.
// Ports:
//   a, b    in  32  operands
//   aluctl  in  4   operation code
//   result  out 32  operation result (wraps modulo 2^32, no overflow trap)
//   zero    out 1   high when result is all zeros
// ----------------------------------------------------------------------------
module alu32
    import exec_decode_unit_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  aluctl,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (aluctl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            // slt compares as two's-complement, not unsigned
            ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
            ALU_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'b0);

endmodule

// File: rtl/exec_decode_unit_alu_ctl_decode.sv
// ----------------------------------------------------------------------------
// alu_ctl_decode
// Chooses the ALU operation from the aluop class and, for R-type, the funct.
// Ports:
//   aluop   in  2   class from main_control
//   funct   in  6   R-type function field
//   aluctl  out 4   ALU operation code
// Anything not explicitly decoded falls back to add.
// ----------------------------------------------------------------------------
module alu_ctl_decode
    import exec_decode_unit_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] aluctl
);

    always_comb begin
        aluctl = ALU_ADD;
        case (aluop)
            ALUOP_BRANCH: aluctl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: aluctl = ALU_ADD;
                    FUNCT_SUB: aluctl = ALU_SUB;
                    FUNCT_AND: aluctl = ALU_AND;
                    FUNCT_OR:  aluctl = ALU_OR;
                    FUNCT_NOR: aluctl = ALU_NOR;
                    FUNCT_SLT: aluctl = ALU_SLT;
                    default:   aluctl = ALU_ADD;
                endcase
            end
            default: aluctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/exec_decode_unit_main_control.sv
// ----------------------------------------------------------------------------
// main_control
// Decodes the 6-bit opcode into the datapath control signals.
// Ports:
//   opcode   in  6   instruction bits [31:26]
//   regdst, alusrc, memtoreg, regwrite, memread, memwrite  out 1 each
//   branch   out 2   bit BRANCH_BEQ / BRANCH_BNE
//   aluop    out 2   ALU usage class for alu_ctl_decode
// Unrecognised opcodes leave every output low, turning them into NOPs.
// ----------------------------------------------------------------------------
module main_control
    import exec_decode_unit_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       regdst,
    output logic       alusrc,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       memread,
    output logic       memwrite,
    output logic [1:0] branch,
    output logic [1:0] aluop
);

    always_comb begin
        regdst   = 1'b0;
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        branch   = 2'b00;
        aluop    = ALUOP_MEM;
        case (opcode)
            OP_RTYPE: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                aluop    = ALUOP_RTYPE;
            end
            OP_LW: begin
                alusrc   = 1'b1;
                memtoreg = 1'b1;
                regwrite = 1'b1;
                memread  = 1'b1;
            end
            OP_SW: begin
                alusrc   = 1'b1;
                memwrite = 1'b1;
            end
            OP_BEQ: begin
                branch[BRANCH_BEQ] = 1'b1;
                aluop              = ALUOP_BRANCH;
            end
            OP_BNE: begin
                branch[BRANCH_BNE] = 1'b1;
                aluop              = ALUOP_BRANCH;
            end
            OP_ADDI: begin
                alusrc   = 1'b1;
                regwrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/exec_decode_unit.sv
// ----------------------------------------------------------------------------
// exec_decode_unit
// EX-stage slice: main decode, ALU-control decode and 32-bit ALU, all
// combinational, plus an EX/MEM capture register for result and zero.
// Ports:
//   clk, reset, flush     in   clock, sync active-high reset, sync flush
//   opcode                in 6  instruction [31:26]
//   a, b_reg, seimm       in 32 rs data, rt data, sign-extended immediate
//   regdst..alusrc        out 1 main control (combinational)
//   branch, aluop         out 2 (combinational)
//   aluctl                out 4 (combinational)
//   result, zero          out   ALU outputs (combinational)
//   result_q, zero_q      out   registered copies for the MEM stage
// ----------------------------------------------------------------------------
module exec_decode_unit
    import exec_decode_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [5:0]  opcode,
    input  logic [31:0] a,
    input  logic [31:0] b_reg,
    input  logic [31:0] seimm,
    output logic        regdst,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        alusrc,
    output logic [1:0]  branch,
    output logic [1:0]  aluop,
    output logic [3:0]  aluctl,
    output logic [31:0] result,
    output logic        zero,
    output logic [31:0] result_q,
    output logic        zero_q
);

    logic [31:0] alu_b;

    main_control u_main_control (
        .opcode   (opcode),
        .regdst   (regdst),
        .alusrc   (alusrc),
        .memtoreg (memtoreg),
        .regwrite (regwrite),
        .memread  (memread),
        .memwrite (memwrite),
        .branch   (branch),
        .aluop    (aluop)
    );

    // funct lives in the low six bits of the sign-extended immediate
    alu_ctl_decode u_alu_ctl_decode (
        .aluop  (aluop),
        .funct  (seimm[5:0]),
        .aluctl (aluctl)
    );

    assign alu_b = alusrc ? seimm : b_reg;

    alu32 u_alu32 (
        .a      (a),
        .b      (alu_b),
        .aluctl (aluctl),
        .result (result),
        .zero   (zero)
    );

    // EX/MEM capture; flush squashes the stage exactly like reset
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= result;
            zero_q   <= zero;
        end
    end

endmodule

// File: tb/tb_exec_decode_unit.sv
// ----------------------------------------------------------------------------
// tb_exec_decode_unit
// Self-checking bench for exec_decode_unit: a directed vector table for the
// combinational decode/ALU, hand sequences for the output register with
// reset and flush, then randomized traffic against a behavioural model.
// ----------------------------------------------------------------------------
module tb_exec_decode_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [5:0]  opcode;
    logic [31:0] a;
    logic [31:0] b_reg;
    logic [31:0] seimm;
    logic        regdst, memread, memwrite, memtoreg, regwrite, alusrc;
    logic [1:0]  branch;
    logic [1:0]  aluop;
    logic [3:0]  aluctl;
    logic [31:0] result;
    logic        zero;
    logic [31:0] result_q;
    logic        zero_q;
    logic [9:0]  ctrl;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exec_decode_unit dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .opcode   (opcode),
        .a        (a),
        .b_reg    (b_reg),
        .seimm    (seimm),
        .regdst   (regdst),
        .memread  (memread),
        .memwrite (memwrite),
        .memtoreg (memtoreg),
        .regwrite (regwrite),
        .alusrc   (alusrc),
        .branch   (branch),
        .aluop    (aluop),
        .aluctl   (aluctl),
        .result   (result),
        .zero     (zero),
        .result_q (result_q),
        .zero_q   (zero_q)
    );

    // Control bundle order: regdst alusrc memtoreg regwrite memread memwrite branch[1:0] aluop[1:0]
    assign ctrl = {regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop};

    typedef struct {
        logic [5:0]  op;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] iv;
        logic [9:0]  ctrl;
        logic [3:0]  aluctl;
        logic [31:0] result;
        logic        zero;
    } vecT;

    typedef struct packed {
        logic [9:0]  ctrl;
        logic [3:0]  aluctl;
        logic [31:0] result;
        logic        zero;
    } expT;

    vecT vecs[15];

    // Behavioural reference: what each instruction means, computed directly
    function automatic expT refModel(input logic [5:0] op, input logic [31:0] av,
                                     input logic [31:0] bv, input logic [31:0] iv);
        expT         e;
        string       kind;
        logic [31:0] opB;
        logic [5:0]  funct;
        funct = iv[5:0];
        kind  = "add";
        e     = '0;
        case (op)
            6'b000000: begin
                e.ctrl = 10'b1001000010;
                case (funct)
                    6'b100010: kind = "sub";
                    6'b100100: kind = "and";
                    6'b100101: kind = "or";
                    6'b100111: kind = "nor";
                    6'b101010: kind = "slt";
                    default:   kind = "add";
                endcase
            end
            6'b100011: e.ctrl = 10'b0111100000;
            6'b101011: e.ctrl = 10'b0100010000;
            6'b000100: begin e.ctrl = 10'b0000000101; kind = "sub"; end
            6'b000101: begin e.ctrl = 10'b0000001001; kind = "sub"; end
            6'b001000: e.ctrl = 10'b0101000000;
            default:   e.ctrl = 10'b0000000000;
        endcase
        opB = (op == 6'b100011 || op == 6'b101011 || op == 6'b001000) ? iv : bv;
        case (kind)
            "sub": begin e.aluctl = 4'b0110; e.result = av - opB; end
            "and": begin e.aluctl = 4'b0000; e.result = av & opB; end
            "or":  begin e.aluctl = 4'b0001; e.result = av | opB; end
            "nor": begin e.aluctl = 4'b1100; e.result = ~(av | opB); end
            "slt": begin e.aluctl = 4'b0111; e.result = ($signed(av) < $signed(opB)) ? 32'd1 : 32'd0; end
            default: begin e.aluctl = 4'b0010; e.result = av + opB; end
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] av,
                                 input logic [31:0] bv, input logic [31:0] iv);
        @(negedge clk);
        opcode = op;
        a      = av;
        b_reg  = bv;
        seimm  = iv;
        #1;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReg(input string name, input logic [31:0] expResult, input logic expZero);
        checkOutput({name, " result_q"}, result_q, expResult);
        checkOutput({name, " zero_q"}, 32'(zero_q), 32'(expZero));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        expT         e;
        logic [31:0] expQ;
        logic        expZq;
        logic [5:0]  opList[6];
        logic [5:0]  functList[6];
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [31:0] av, bv, iv, tmp;

        opList    = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000};
        functList = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};

        vecs[0]  = '{6'b000000, 32'd5, 32'd7, 32'h20, 10'b1001000010, 4'b0010, 32'd12, 1'b0};
        vecs[1]  = '{6'b100011, 32'h100, 32'hDEAD, 32'h10, 10'b0111100000, 4'b0010, 32'h110, 1'b0};
        vecs[2]  = '{6'b101011, 32'h200, 32'h55, 32'hFFFFFFFC, 10'b0100010000, 4'b0010, 32'h1FC, 1'b0};
        vecs[3]  = '{6'b000100, 32'h1234, 32'h1234, 32'h0, 10'b0000000101, 4'b0110, 32'h0, 1'b1};
        vecs[4]  = '{6'b000101, 32'd3, 32'd4, 32'h0, 10'b0000001001, 4'b0110, 32'hFFFFFFFF, 1'b0};
        vecs[5]  = '{6'b001000, 32'd10, 32'd99, 32'hFFFFFFF6, 10'b0101000000, 4'b0010, 32'h0, 1'b1};
        vecs[6]  = '{6'b000000, 32'hFFFFFFFF, 32'd1, 32'h2A, 10'b1001000010, 4'b0111, 32'd1, 1'b0};
        vecs[7]  = '{6'b000000, 32'd1, 32'hFFFFFFFF, 32'h2A, 10'b1001000010, 4'b0111, 32'd0, 1'b1};
        vecs[8]  = '{6'b000000, 32'h0, 32'h0, 32'h27, 10'b1001000010, 4'b1100, 32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{6'b000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h24, 10'b1001000010, 4'b0000, 32'hF000F000, 1'b0};
        vecs[10] = '{6'b000000, 32'hF0F0F0F0, 32'h0F0F0000, 32'h25, 10'b1001000010, 4'b0001, 32'hFFFFF0F0, 1'b0};
        vecs[11] = '{6'b000000, 32'd7, 32'd7, 32'h22, 10'b1001000010, 4'b0110, 32'd0, 1'b1};
        vecs[12] = '{6'b000000, 32'd1, 32'd2, 32'h3F, 10'b1001000010, 4'b0010, 32'd3, 1'b0};
        vecs[13] = '{6'b111111, 32'd4, 32'd5, 32'd100, 10'b0000000000, 4'b0010, 32'd9, 1'b0};
        vecs[14] = '{6'b000000, 32'd1, 32'd1, 32'hFFFF8020, 10'b1001000010, 4'b0010, 32'd2, 1'b0};

        // Reset state: inputs give zero=1, but reset must hold zero_q low
        reset  = 1'b1;
        flush  = 1'b0;
        opcode = '0;
        a      = '0;
        b_reg  = '0;
        seimm  = '0;
        clockEdge();
        clockEdge();
        checkReg("reset state", 32'd0, 1'b0);
        reset = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].iv);
            checkOutput($sformatf("vec%0d ctrl", i), 32'(ctrl), 32'(vecs[i].ctrl));
            checkOutput($sformatf("vec%0d aluctl", i), 32'(aluctl), 32'(vecs[i].aluctl));
            checkOutput($sformatf("vec%0d result", i), result, vecs[i].result);
            checkOutput($sformatf("vec%0d zero", i), 32'(zero), 32'(vecs[i].zero));
        end

        $display("[TB] register sequences");
        applyStimulus(6'b000000, 32'd5, 32'd7, 32'h20);
        clockEdge();
        checkReg("add capture", 32'd12, 1'b0);
        reset = 1'b1;
        clockEdge();
        checkReg("reset discard", 32'd0, 1'b0);
        reset = 1'b0;
        clockEdge();
        checkReg("reload after reset", 32'd12, 1'b0);
        flush = 1'b1;
        clockEdge();
        checkReg("flush", 32'd0, 1'b0);
        flush = 1'b0;
        applyStimulus(6'b000100, 32'h1234, 32'h1234, 32'h0);
        clockEdge();
        checkReg("beq capture", 32'd0, 1'b1);
        applyStimulus(6'b000000, 32'd5, 32'd7, 32'h20);
        reset = 1'b1;
        flush = 1'b1;
        clockEdge();
        checkReg("reset+flush", 32'd0, 1'b0);
        reset = 1'b0;
        flush = 1'b0;
        clockEdge();
        checkReg("reload after reset+flush", 32'd12, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++) begin
            int sel;
            sel   = $urandom_range(0, 6);
            op    = (sel < 6) ? opList[sel] : 6'($urandom);
            sel   = $urandom_range(0, 6);
            funct = (sel < 6) ? functList[sel] : 6'($urandom);
            av    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            bv    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            if ($urandom_range(0, 7) == 0) bv = av;
            tmp   = $urandom;
            iv    = {tmp[31:6], funct};
            applyStimulus(op, av, bv, iv);
            reset = ($urandom_range(0, 15) == 0);
            flush = ($urandom_range(0, 15) == 0);
            #1;
            e = refModel(op, av, bv, iv);
            checkOutput($sformatf("rand%0d ctrl", i), 32'(ctrl), 32'(e.ctrl));
            checkOutput($sformatf("rand%0d aluctl", i), 32'(aluctl), 32'(e.aluctl));
            checkOutput($sformatf("rand%0d result", i), result, e.result);
            checkOutput($sformatf("rand%0d zero", i), 32'(zero), 32'(e.zero));
            if (reset || flush) begin
                expQ  = 32'd0;
                expZq = 1'b0;
            end else begin
                expQ  = e.result;
                expZq = e.zero;
            end
            clockEdge();
            checkReg($sformatf("rand%0d", i), expQ, expZq);
        end
        reset = 1'b0;
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
